// File: rtl/mem_pkg.sv
// Shared constants and types for the 32K x 16 word-addressed memory.
package mem_pkg;

    localparam int MEM_AW     = 15;
    localparam int MEM_DW     = 16;
    localparam int MEM_RD_LAT = 2;

    typedef logic [15:1] mem_addr_t;
    typedef logic [15:0] mem_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward with wrap.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [N-1:0]  upper;
    logic [N-1:0]  pick;
    logic          found;

    // Prefer requests at or above ptr; if none, wrap to the lowest request.
    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (IW'(i) >= ptr);
        end
        pick      = (|upper) ? upper : req;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && pick[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end

    // Pointer moves just past the winner; wraps at N-1 even when N is not a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory read and write ports among NREQ requesters and
// routes each read word back to its issuer after the fixed read latency.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*MEM_AW-1:0] req_addr,
    input  logic [NREQ*MEM_DW-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output mem_data_t              rsp_data,
    output mem_addr_t              mem_raddr,
    input  mem_data_t              mem_rdata,
    output logic                   mem_wen,
    output mem_addr_t              mem_waddr,
    output mem_data_t              mem_wdata,
    output logic                   busy
);

    logic [NREQ-1:0]                 req_live;
    logic [NREQ-1:0]                 grant;
    logic [IDW-1:0]                  gidx;
    logic                            any_grant;
    logic                            g_we;
    logic                            rd_grant;
    mem_addr_t                       g_addr;
    mem_data_t                       g_wdata;
    mem_addr_t                       raddr_q;
    logic [MEM_RD_LAT-1:0]           vld_pipe;
    logic [MEM_RD_LAT-1:0][IDW-1:0]  id_pipe;

    // No grants while reset is asserted, even if requesters hold valid.
    assign req_live  = req_valid & {NREQ{rst_n}};
    assign any_grant = |req_live;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_live),
        .advance   (any_grant),
        .grant     (grant),
        .grant_idx (gidx)
    );

    // Select the winning requester's payload slice.
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_addr  = req_addr[i*MEM_AW +: MEM_AW];
                g_wdata = req_wdata[i*MEM_DW +: MEM_DW];
                g_we    = req_we[i];
            end
        end
    end

    assign rd_grant  = any_grant && !g_we;
    assign req_ready = grant;
    assign mem_wen   = any_grant && g_we;
    assign mem_waddr = g_addr;
    assign mem_wdata = g_wdata;

    // Read address follows the grant, otherwise holds so the read port stays quiet.
    assign mem_raddr = rd_grant ? g_addr : raddr_q;

    // Remember the last driven read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= mem_raddr;
        end
    end

    // In-flight tracker: one slot per cycle of memory read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MEM_RD_LAT-2:0], rd_grant};
            id_pipe  <= {id_pipe[MEM_RD_LAT-2:0], gidx};
        end
    end

    assign rsp_valid = vld_pipe[MEM_RD_LAT-1] ? (NREQ'(1) << id_pipe[MEM_RD_LAT-1]) : '0;
    assign rsp_data  = mem_rdata;
    assign busy      = |vld_pipe;

endmodule
